// File: rtl/seg7_pkg.sv
// Shared types, constants and the ASCII to active-low 7-segment decode
// used by the scan driver.
package seg7_pkg;

   typedef enum logic {BLANK, SHOW} scan_state_t;

   localparam logic [7:0] SEG_BLANK   = 8'hFF;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [6:0] ASCII_DASH  = 7'h2D;
   localparam logic [6:0] ASCII_LC_A  = 7'h61;
   localparam logic [6:0] ASCII_LC_Z  = 7'h7A;

   // Returns {dp, g..a} active-low; dp is always off. The table is active-high gfedcba.
   function automatic logic [7:0] ascii_to_seg7(input logic [6:0] code);
      logic [6:0] c;
      logic [6:0] on;
      c = code;
      if (c >= ASCII_LC_A && c <= ASCII_LC_Z) c = c - 7'd32;
      case (c)
         7'h30: on = 7'h3F;
         7'h31: on = 7'h06;
         7'h32: on = 7'h5B;
         7'h33: on = 7'h4F;
         7'h34: on = 7'h66;
         7'h35: on = 7'h6D;
         7'h36: on = 7'h7D;
         7'h37: on = 7'h07;
         7'h38: on = 7'h7F;
         7'h39: on = 7'h6F;
         7'h41: on = 7'h77;
         7'h42: on = 7'h7C;
         7'h43: on = 7'h39;
         7'h44: on = 7'h5E;
         7'h45: on = 7'h79;
         7'h46: on = 7'h71;
         7'h47: on = 7'h3D;
         7'h48: on = 7'h76;
         7'h49: on = 7'h30;
         7'h4A: on = 7'h1E;
         7'h4B: on = 7'h75;
         7'h4C: on = 7'h38;
         7'h4D: on = 7'h37;
         7'h4E: on = 7'h54;
         7'h4F: on = 7'h3F;
         7'h50: on = 7'h73;
         7'h51: on = 7'h67;
         7'h52: on = 7'h50;
         7'h53: on = 7'h6D;
         7'h54: on = 7'h78;
         7'h55: on = 7'h3E;
         7'h56: on = 7'h1C;
         7'h57: on = 7'h2A;
         7'h58: on = 7'h76;
         7'h59: on = 7'h6E;
         7'h5A: on = 7'h5B;
         ASCII_DASH: on = 7'h40;
         default: on = 7'h00;
      endcase
      return {1'b1, ~on};
   endfunction

endpackage

// File: rtl/seg7_ascii_decode.sv
// Combinational wrapper around ascii_to_seg7 for one character; only the
// low 7 bits of the character take part in the decode.
module seg7_ascii_decode
   import seg7_pkg::*;
#(
   parameter int CHAR_WIDTH = 8
) (
   input  logic [CHAR_WIDTH-1:0] ch,
   output logic [7:0]            seg_n
);

   assign seg_n = ascii_to_seg7(ch[6:0]);

   if (CHAR_WIDTH > 7) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^ch[CHAR_WIDTH-1:7];
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan with a double-buffered frame of characters.
// Optional SEG7_DIM_PWM_EN adds per-slot PWM dimming driven by brightness.
//
// state | meaning
// BLANK | all-off anti-ghosting gap at the start of a digit slot
// SHOW  | selected digit enabled with its decoded pattern
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int CHAR_WIDTH   = 8,
   parameter int NUM_DISPLAYS = 6,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   load,
   input  logic [NUM_DISPLAYS-1:0][CHAR_WIDTH-1:0] chars_in,
   input  logic [3:0]                             brightness,
   output logic [7:0]                             seg_n,
   output logic [NUM_DISPLAYS-1:0]                dig_en_n,
   output logic                                   frame_done
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DIG_W = (NUM_DISPLAYS > 1) ? $clog2(NUM_DISPLAYS) : 1;
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);
   localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DISPLAYS - 1);

   scan_state_t                            state;
   logic [CNT_W-1:0]                       slot_cnt;
   logic [DIG_W-1:0]                       digit;
   logic [NUM_DISPLAYS-1:0][CHAR_WIDTH-1:0] active;
   logic [NUM_DISPLAYS-1:0][CHAR_WIDTH-1:0] pending;
   logic                                   pending_valid;
   logic [7:0]                             dec_seg;
   logic                                   frame_end;
   logic                                   show_entry;
   logic                                   lit;

   assign frame_end  = (state == SHOW) && (slot_cnt == SHOW_LAST) && (digit == DIG_LAST);
   assign show_entry = (state == BLANK) && (slot_cnt == BLANK_LAST);

   seg7_ascii_decode #(.CHAR_WIDTH(CHAR_WIDTH)) u_dec (
      .ch    (active[digit]),
      .seg_n (dec_seg)
   );

`ifdef SEG7_DIM_PWM_EN
   logic [3:0] pwm_cnt;
   logic [3:0] bright_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt  <= 4'd0;
         bright_q <= 4'd0;
      end else if (show_entry) begin
         pwm_cnt  <= 4'd0;
         bright_q <= brightness;
      end else if (state == SHOW) begin
         pwm_cnt  <= pwm_cnt + 4'd1;
      end
   end

   assign lit = (pwm_cnt < bright_q);
`else
   logic unused_brightness;
   assign unused_brightness = ^brightness;
   assign lit = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BLANK;
         slot_cnt   <= '0;
         digit      <= '0;
         seg_n      <= SEG_BLANK;
         dig_en_n   <= '1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_end;
         seg_n      <= SEG_BLANK;
         dig_en_n   <= '1;
         if (state == SHOW && lit) begin
            seg_n    <= dec_seg;
            dig_en_n <= ~(NUM_DISPLAYS'(1) << digit);
         end
         case (state)
            BLANK: begin
               if (show_entry) begin
                  state    <= SHOW;
                  slot_cnt <= '0;
               end else begin
                  slot_cnt <= slot_cnt + CNT_W'(1);
               end
            end
            SHOW: begin
               if (slot_cnt == SHOW_LAST) begin
                  state    <= BLANK;
                  slot_cnt <= '0;
                  digit    <= (digit == DIG_LAST) ? '0 : digit + DIG_W'(1);
               end else begin
                  slot_cnt <= slot_cnt + CNT_W'(1);
               end
            end
            default: state <= BLANK;
         endcase
      end
   end

   // A load coinciding with the frame boundary bypasses the pending buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active        <= {NUM_DISPLAYS{CHAR_WIDTH'(ASCII_SPACE)}};
         pending       <= {NUM_DISPLAYS{CHAR_WIDTH'(ASCII_SPACE)}};
         pending_valid <= 1'b0;
      end else begin
         if (load) pending <= chars_in;
         if (frame_end) begin
            if (load) active <= chars_in;
            else if (pending_valid) active <= pending;
            pending_valid <= 1'b0;
         end else if (load) begin
            pending_valid <= 1'b1;
         end
      end
   end

endmodule
